sp_ram_pipe_model: RTL

Parametrised single-port RAM model for simulation and FPGA (array mapped to block RAM), the successor to the team's basic single-port model. Adds configurable read latency with a read-data-valid pipeline, a selectable write-port output mode, and an optional post-reset clear sweep with a ready indication. It sits behind cache/tag/data arrays and queues that need deterministic latency and known initial contents.

---
 rtl/sp_ram_pipe_model.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sp_ram_pipe_model.sv
// sp_ram_pipe_model
// Single-port RAM model with a configurable read-latency pipeline, a
// selectable write-port output mode and an optional post-reset clear sweep.
//
// Parameters
//   ADDR_WIDTH   address bits, DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH   word width
//   READ_LATENCY accept-to-DO latency in cycles (1..4)
//   WRITE_MODE   0 = NO_CHANGE (writes give no DV), 1 = WRITE_FIRST (writes
//                return the merged stored word with DV)
//   INIT_CLEAR   1 = sweep every word to INIT_VALUE after reset
//   INIT_VALUE   clear value
//
// Ports
//   CLK    clock, all state on rising edge
//   RST    asynchronous active-high reset
//   CE     request strobe, accepted when CE && READY
//   RDWEN  1 = write, 0 = read
//   A      word address
//   DI     write data
//   BW     per-bit write enable
//   READY  requests are accepted (registered FSM state == RUN)
//   DO     read data, holds between valid returns
//   DV     one-cycle pulse, DO carries new data
module sp_ram_pipe_model #(
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    READ_LATENCY = 1,
    parameter int                    WRITE_MODE   = 0,
    parameter int                    INIT_CLEAR   = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  RDWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic [DATA_WIDTH-1:0] BW,
    output logic                  READY,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  DV
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // The counter is one bit wider than the address so the terminal
    // compare never has to rely on wrap-around.
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH:0]   clr_cnt_reg;
    logic [ADDR_WIDTH:0]   clr_cnt_next;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic [READ_LATENCY-1:0] valid_pipe;
    logic [DATA_WIDTH-1:0]   data_pipe [READ_LATENCY];

    logic accept;
    logic launch_valid;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                state_next = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_INIT;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    assign READY  = (state_reg == ST_RUN);
    assign accept = CE && READY;

    // Writes only launch into the return pipeline in WRITE_FIRST mode.
    assign launch_valid = accept && (!RDWEN || (WRITE_MODE == 1));

    // ------------------------------------------------------------------
    // Storage: one write port shared between the clear sweep and requests.
    // Contents are deliberately left out of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (state_reg == ST_CLEAR) begin
            ram[clr_cnt_reg[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        end else if (accept && RDWEN) begin
            ram[A] <= (ram[A] & ~BW) | (DI & BW);
        end
    end

    // ------------------------------------------------------------------
    // Return pipeline. Stage 0 captures the word at the accepting edge
    // (old contents for reads, merged word for writes), so a write is
    // visible to a read accepted on the very next edge without forwarding.
    // Every stage only loads data with a valid bit, which makes the final
    // stage (DO) hold between returns.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_pipe[i] <= '0;
            end
        end else begin
            valid_pipe[0] <= launch_valid;
            if (launch_valid) begin
                data_pipe[0] <= RDWEN ? ((ram[A] & ~BW) | (DI & BW)) : ram[A];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                if (valid_pipe[i-1]) begin
                    data_pipe[i] <= data_pipe[i-1];
                end
            end
        end
    end

    assign DO = data_pipe[READ_LATENCY-1];
    assign DV = valid_pipe[READ_LATENCY-1];

endmodule
